// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/grant encodings and constants for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam logic [2:0] F3_WORD = 3'b010;
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;
    typedef enum logic [1:0] {
        PICK_NONE  = 2'd0,
        PICK_FETCH = 2'd1,
        PICK_DATA  = 2'd2
    } pick_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_func3;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_func3;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_ready, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               mem_func3, busy
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_ready, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               mem_func3, busy
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: data-priority winner select, overridden when fetch has been starved too long
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output pick_t            pick
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic starved;
    assign starved = if_req & (starve_cnt == LIMIT);
    assign pick    = (d_req & ~starved) ? PICK_DATA : (if_req ? PICK_FETCH : PICK_NONE);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store traffic
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    arb_state_t        state, state_nx;
    pick_t             pick;
    logic              resp_d, resp_d_nx;
    logic              we_q, we_nx;
    logic [CNT_W-1:0]  starve_cnt, starve_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [2:0]        f3_q, f3_nx;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_nx;
    logic              is_d;
    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_pick (
        .if_req    (bus.if_req),
        .d_req     (bus.d_req),
        .starve_cnt(starve_cnt),
        .pick      (pick)
    );
    assign is_d = pick == PICK_DATA;
    always_comb begin
        state_nx    = state;
        resp_d_nx   = resp_d;
        we_nx       = we_q;
        starve_nx   = starve_cnt;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        f3_nx       = f3_q;
        if_rdata_nx = if_rdata_q;
        d_rdata_nx  = d_rdata_q;
        case (state)
            ARB_IDLE: if (pick != PICK_NONE) begin
                state_nx  = is_d ? ARB_BUSY_D : ARB_BUSY_I;
                resp_d_nx = is_d;
                we_nx     = is_d & bus.d_we;
                addr_nx   = is_d ? bus.d_addr : bus.if_addr;
                wdata_nx  = is_d ? bus.d_wdata : '0;
                f3_nx     = is_d ? bus.d_func3 : F3_WORD;
                // Saturating count of data wins while fetch waits; any other grant clears it
                starve_nx = (is_d & bus.if_req) ? starve_cnt + CNT_W'(starve_cnt != LIMIT) : '0;
            end
            ARB_BUSY_I, ARB_BUSY_D: if (bus.mem_ready) begin
                state_nx    = ARB_RESP;
                if_rdata_nx = state == ARB_BUSY_I ? bus.mem_rdata : if_rdata_q;
                d_rdata_nx  = state == ARB_BUSY_D ? bus.mem_rdata : d_rdata_q;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            resp_d     <= 1'b0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nx;
            resp_d     <= resp_d_nx;
            we_q       <= we_nx;
            starve_cnt <= starve_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            f3_q       <= f3_nx;
            if_rdata_q <= if_rdata_nx;
            d_rdata_q  <= d_rdata_nx;
        end
    end
    assign bus.mem_req   = (state == ARB_BUSY_I) | (state == ARB_BUSY_D);
    assign bus.mem_we    = (state == ARB_BUSY_D) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_func3 = f3_q;
    assign bus.if_ready  = (state == ARB_RESP) & ~resp_d;
    assign bus.d_ready   = (state == ARB_RESP) & resp_d;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = state != ARB_IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a latency-programmable memory model and requester models
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0, cyc = 0, n_rdy = 0, rdy_cyc = 0;
    int mem_lat = 0, wcnt = 0, d_again = 0;
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic push(input logic is_d, input logic chk, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = data;
        sb.push_back(e);
    endtask

    // One cycle: sample outputs at the falling edge, pop the scoreboard, then drive requester/memory models
    task automatic step();
        exp_t e;
        logic [31:0] got;
        @(negedge clk);
        cyc++;
        if (bus.if_ready || bus.d_ready) begin
            n_rdy++;
            rdy_cyc = cyc;
            checks++;
            if (bus.if_ready && bus.d_ready) begin
                errors++;
                $display("FAIL ready_excl: if_ready=1 d_ready=1, required only one");
            end
            checks++;
            got = bus.d_ready ? bus.d_rdata : bus.if_rdata;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: unexpected ready if=%0b d=%0b, required none", bus.if_ready, bus.d_ready);
            end else begin
                e = sb.pop_front();
                if (bus.d_ready !== e.is_d || (e.chk && got !== e.data)) begin
                    errors++;
                    $display("FAIL sb_resp: got d_ready=%0b rdata=%h, required d_ready=%0b rdata=%h",
                             bus.d_ready, got, e.is_d, e.data);
                end
            end
            if (bus.if_ready) bus.if_req = 1'b0;
            if (bus.d_ready) begin
                if (d_again > 0) d_again--;
                else bus.d_req = 1'b0;
            end
        end
        bus.mem_ready = 1'b0;
        if (bus.mem_req) begin
            if (wcnt == mem_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_rd(bus.mem_addr);
                if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < max) begin
            step();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL timeout: %0d cycles with %0d responses outstanding, required 0", n, sb.size());
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL %s_ctrl: req/we/if_rdy/d_rdy/busy=%b, required 00000", name,
                     {bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.busy});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_func3, bus.if_rdata, bus.d_rdata} !== '0) begin
            errors++;
            $display("FAIL %s_data: addr=%h wdata=%h f3=%b if_rdata=%h d_rdata=%h, required all 0", name,
                     bus.mem_addr, bus.mem_wdata, bus.mem_func3, bus.if_rdata, bus.d_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        check_idle_zero("reset");
        rst = 1'b1;
        step();
        check_idle_zero("post_reset");
    endtask

    task automatic test_fetch();
        mem_m[32'h40] = 32'h0050_0093;
        mem_lat = 0;
        push(1'b0, 1'b1, 32'h0050_0093);
        bus.if_addr = 32'h40;
        bus.if_req = 1'b1;
        cyc = 0;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_func3, bus.mem_addr} !== {1'b1, 1'b0, 3'b010, 32'h40}) begin
            errors++;
            $display("FAIL fetch_cmd: req=%b we=%b f3=%b addr=%h, required 1 0 010 00000040",
                     bus.mem_req, bus.mem_we, bus.mem_func3, bus.mem_addr);
        end
        step();
        checks++;
        if (bus.if_ready !== 1'b1 || cyc != 2) begin
            errors++;
            $display("FAIL fetch_lat: if_ready=%b in cycle %0d, required 1 in cycle 2", bus.if_ready, cyc);
        end
        run(20);
    endtask

    task automatic test_store();
        int held = 0, n0 = n_rdy;
        logic bad = 1'b0;
        mem_lat = 3;
        push(1'b1, 1'b0, 32'h0);
        bus.d_we = 1'b1;
        bus.d_addr = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_func3 = 3'b000;
        bus.d_req = 1'b1;
        cyc = 0;
        repeat (6) begin
            step();
            if (bus.mem_req) begin
                held++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_func3} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 3'b000})
                    bad = 1'b1;
            end
        end
        checks++;
        if (held != 4 || bad) begin
            errors++;
            $display("FAIL store_hold: held %0d cycles unstable=%b, required 4 stable", held, bad);
        end
        checks++;
        if (n_rdy - n0 != 1 || rdy_cyc != 5) begin
            errors++;
            $display("FAIL store_ready: %0d pulses last in cycle %0d, required 1 in cycle 5", n_rdy - n0, rdy_cyc);
        end
        checks++;
        if (mem_rd(32'h100) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_mem: memory holds %h, required deadbeef", mem_rd(32'h100));
        end
        bus.d_we = 1'b0;
        run(20);
    endtask

    task automatic test_tie();
        mem_lat = 1;
        mem_m[32'h200] = 32'h1111_2222;
        push(1'b1, 1'b1, 32'h1111_2222);
        push(1'b0, 1'b1, mem_rd(32'h44));
        bus.d_addr = 32'h200;
        bus.d_func3 = 3'b010;
        bus.if_addr = 32'h44;
        bus.d_req = 1'b1;
        bus.if_req = 1'b1;
        cyc = 0;
        run(50);
        checks++;
        if (rdy_cyc != 7) begin
            errors++;
            $display("FAIL tie_timing: fetch ready in cycle %0d, required 7", rdy_cyc);
        end
    endtask

    task automatic test_starve();
        int n = 0;
        mem_lat = 0;
        repeat (4) push(1'b1, 1'b1, mem_rd(32'h300));
        push(1'b0, 1'b1, mem_rd(32'h48));
        push(1'b1, 1'b1, mem_rd(32'h300));
        bus.d_addr = 32'h300;
        bus.if_addr = 32'h48;
        d_again = 4;
        bus.d_req = 1'b1;
        bus.if_req = 1'b1;
        while ((sb.size() != 0 || bus.busy) && n < 200) begin
            step();
            n++;
            if (bus.if_ready) begin
                checks++;
                if (dut.starve_cnt !== 3'd0) begin
                    errors++;
                    $display("FAIL starve_clear: starve_cnt=%0d after fetch grant, required 0", dut.starve_cnt);
                end
            end
        end
        checks++;
        if (n >= 200 || d_again != 0) begin
            errors++;
            $display("FAIL starve_done: %0d cycles, %0d data re-requests left, required <200 and 0", n, d_again);
        end
    endtask

    task automatic test_drop();
        int n0 = n_rdy;
        mem_lat = 2;
        push(1'b1, 1'b1, mem_rd(32'h304));
        bus.d_addr = 32'h304;
        bus.d_req = 1'b1;
        step();
        bus.d_req = 1'b0;
        run(50);
        checks++;
        if (n_rdy - n0 != 1) begin
            errors++;
            $display("FAIL drop_ready: %0d pulses, required 1", n_rdy - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        mem_lat = 10;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h308;
        bus.d_wdata = 32'h1234_5678;
        bus.d_req = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: mem_req=%b mem_we=%b, required 1 1", bus.mem_req, bus.mem_we);
        end
        n0 = n_rdy;
        rst = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        repeat (2) step();
        check_idle_zero("midrst");
        rst = 1'b1;
        repeat (4) step();
        checks++;
        if (n_rdy != n0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: %0d pulses busy=%b mem_req=%b, required 0 0 0", n_rdy - n0, bus.busy, bus.mem_req);
        end
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_func3 = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_starve();
        test_drop();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left: %0d responses never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
